// File: rtl/key_input_ctrl.sv
// Push-button front end: per-key 2-flop sync, polarity normalise, debounce,
// press/release pulses and an auto-repeat timer feeding the game control FSM.
module key_input_ctrl #(
  parameter int NUM_KEYS        = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_event,
  output logic                any_event
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  // Synchroniser resets to the raw "released" level so no phantom press follows reset.
  localparam logic [NUM_KEYS-1:0] RAW_IDLE = ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, key_norm;
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;
  logic [NUM_KEYS-1:0] accept;
  logic [DW-1:0]       deb_cnt_q [NUM_KEYS];
  logic [DW-1:0]       deb_cnt_d [NUM_KEYS];
  logic [RW-1:0]       rpt_cnt_q [NUM_KEYS];
  logic [RW-1:0]       rpt_cnt_d [NUM_KEYS];
  rpt_state_e          state_q   [NUM_KEYS];
  rpt_state_e          state_d   [NUM_KEYS];

  assign key_norm = ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= RAW_IDLE;
      sync2_q   <= RAW_IDLE;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        deb_cnt_q[k] <= '0;
        rpt_cnt_q[k] <= '0;
        state_q[k]   <= ST_IDLE;
      end
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      for (int k = 0; k < NUM_KEYS; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
        rpt_cnt_q[k] <= rpt_cnt_d[k];
        state_q[k]   <= state_d[k];
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    accept    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      deb_cnt_d[k] = '0;
      rpt_cnt_d[k] = rpt_cnt_q[k];
      state_d[k]   = state_q[k];

      // Any sample agreeing with the accepted level restarts the stability window.
      if (key_norm[k] != level_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          accept[k]    = 1'b1;
          level_d[k]   = ~level_q[k];
          press_d[k]   = ~level_q[k];
          release_d[k] = level_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end

      // Timers run regardless of repeat_en so re-enabling keeps the original cadence.
      case (state_q[k])
        ST_IDLE: begin
          if (accept[k] && !level_q[k]) begin
            state_d[k]   = ST_DELAY;
            rpt_cnt_d[k] = '0;
          end
        end
        ST_DELAY: begin
          if (rpt_cnt_q[k] == DLY_LAST) begin
            state_d[k]   = ST_REPEAT;
            rpt_cnt_d[k] = '0;
            repeat_d[k]  = repeat_en;
          end else begin
            rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rpt_cnt_q[k] == PER_LAST) begin
            rpt_cnt_d[k] = '0;
            repeat_d[k]  = repeat_en;
          end else begin
            rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k]   = ST_IDLE;
          rpt_cnt_d[k] = '0;
        end
      endcase

      if (accept[k] && level_q[k]) begin
        state_d[k]   = ST_IDLE;
        rpt_cnt_d[k] = '0;
        repeat_d[k]  = 1'b0;
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign key_event   = press_q | repeat_q;
  assign any_event   = |key_event;

endmodule
